mem_access_stage: RTL and testbench

Pipeline MEM stage of the single-issue RISC-V core, directly downstream of the EX/MEM register. Unpacks the 72-bit EX/MEM word, runs any load or store over a request/acknowledge data-memory bus, stalls upstream stages while the bus is busy, and owns the packed 70-bit MEM/WB pipeline register that feeds write-back.

---
 rtl/riscv_pipe_pkg.sv | 40 ++++
 rtl/mem_access_timer.sv | 45 ++++
 rtl/mem_access_stage.sv | 151 +++++++++++++++
 tb/tb_mem_access_stage.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pipe_pkg.sv
// Shared definitions for the pipeline registers around the MEM stage.
// Holds the EX/MEM (72-bit) and MEM/WB (70-bit) field layouts, the MEM-stage
// state enum, the write-back bubble constant and a MEM/WB packing helper.
package riscv_pipe_pkg;

  localparam int unsigned ExMemW = 72;
  localparam int unsigned MemWbW = 70;
  localparam int unsigned RdW    = 5;
  localparam int unsigned XlenW  = 32;

  // EX/MEM field positions
  localparam int unsigned ExMemReadBit  = 71;
  localparam int unsigned ExMemWriteBit = 70;
  localparam int unsigned ExMemToRegBit = 69;
  localparam int unsigned ExRdLsb       = 64;
  localparam int unsigned ExWdataLsb    = 32;
  localparam int unsigned ExAluLsb      = 0;

  // MEM/WB field positions
  localparam int unsigned WbMemToRegBit = 69;
  localparam int unsigned WbRdLsb       = 64;
  localparam int unsigned WbRdataLsb    = 32;
  localparam int unsigned WbAluLsb      = 0;

  typedef enum logic [0:0] {
    IDLE,
    ACCESS
  } mem_state_e;

  // All-zero word: RD=0 means no register write in WB.
  localparam logic [MemWbW-1:0] MemWbBubble = '0;

  function automatic logic [MemWbW-1:0] pack_mem_wb(input logic             mem_to_reg,
                                                    input logic [RdW-1:0]   rd,
                                                    input logic [XlenW-1:0] rdata,
                                                    input logic [XlenW-1:0] alu);
    return {mem_to_reg, rd, rdata, alu};
  endfunction

endpackage

// File: rtl/mem_access_timer.sv
// Bus-access watchdog for the MEM stage.
// Counts ACCESS cycles that end without an acknowledge and flags the cycle in
// which the limit is reached, so the stage can abort the access.
// Ports:
//   clk       clock (state updates on the falling edge)
//   reset     asynchronous active-low reset
//   clear_i   restart the count (entry into ACCESS)
//   active_i  stage is in ACCESS this cycle
//   ack_i     bus acknowledge this cycle
//   timeout_o combinational: this ACCESS cycle is the last one allowed
module mem_access_timer #(
  parameter int unsigned Limit = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic active_i,
  input  logic ack_i,
  output logic timeout_o
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (active_i && !ack_i) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q counts completed wait cycles, so the Limit-th ACCESS cycle sees Limit-1.
  // An ack in that same cycle wins.
  assign timeout_o = active_i && !ack_i && (cnt_q == 8'(Limit - 1));

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: unpacks the EX/MEM word, runs loads/stores over a
// request/acknowledge data bus, stalls upstream while the bus is busy and owns
// the MEM/WB pipeline register. All state updates on the falling clock edge.
// Optional feature macro: MEM_TIMEOUT_EN (access watchdog with bus_error).
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   ex_mem_in  [71:0]   {MemRead, MemWrite, MemToReg, RD, store data, ALU result}
//   dmem_req/we/addr/wdata  bus request side; dmem_rdata/dmem_ack response side
//   stall               combinational freeze of PC, IF/ID, ID/EX and EX/MEM
//   mem_wb_out [69:0]   {MemToReg, RD, read data, ALU result}
//   bus_error           one-cycle pulse after a timeout abort (0 without feature)
module mem_access_stage
  import riscv_pipe_pkg::*;
#(
  parameter logic [MemWbW-1:0] INIT_VALUE     = '0,
  parameter int unsigned       TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ExMemW-1:0] ex_mem_in,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [XlenW-1:0]  dmem_addr,
  output logic [XlenW-1:0]  dmem_wdata,
  input  logic [XlenW-1:0]  dmem_rdata,
  input  logic              dmem_ack,
  output logic              stall,
  output logic [MemWbW-1:0] mem_wb_out,
  output logic              bus_error
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..255");
  end

  // EX/MEM unpack
  logic             in_read, in_write, in_mtr, in_mem_op;
  logic [RdW-1:0]   in_rd;
  logic [XlenW-1:0] in_wdata, in_alu;

  assign in_read   = ex_mem_in[ExMemReadBit];
  assign in_write  = ex_mem_in[ExMemWriteBit];
  assign in_mtr    = ex_mem_in[ExMemToRegBit];
  assign in_rd     = ex_mem_in[ExRdLsb +: RdW];
  assign in_wdata  = ex_mem_in[ExWdataLsb +: XlenW];
  assign in_alu    = ex_mem_in[ExAluLsb +: XlenW];
  assign in_mem_op = in_read | in_write;

  mem_state_e        state_q, state_d;
  logic [XlenW-1:0]  addr_q, addr_d, wdata_q, wdata_d;
  logic              we_q, we_d, mtr_q, mtr_d;
  logic [RdW-1:0]    rd_q, rd_d;
  logic [MemWbW-1:0] mem_wb_q, mem_wb_d;
  logic              timeout;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    mtr_d    = mtr_q;
    rd_d     = rd_q;
    mem_wb_d = mem_wb_q;
    stall    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_mem_op) begin
          stall    = 1'b1;
          addr_d   = in_alu;
          wdata_d  = in_wdata;
          // MemRead+MemWrite together is treated as a store.
          we_d     = in_write;
          mtr_d    = in_mtr;
          rd_d     = in_rd;
          mem_wb_d = MemWbBubble;
          state_d  = ACCESS;
        end else begin
          mem_wb_d = pack_mem_wb(in_mtr, in_rd, '0, in_alu);
        end
      end
      ACCESS: begin
        if (dmem_ack) begin
          mem_wb_d = pack_mem_wb(mtr_q, rd_q, we_q ? '0 : dmem_rdata, addr_q);
          state_d  = IDLE;
        end else if (timeout) begin
          mem_wb_d = MemWbBubble;
          state_d  = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      mtr_q    <= 1'b0;
      rd_q     <= '0;
      mem_wb_q <= INIT_VALUE;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      mtr_q    <= mtr_d;
      rd_q     <= rd_d;
      mem_wb_q <= mem_wb_d;
    end
  end

  // Request follows the state directly so reset drops it asynchronously.
  assign dmem_req   = (state_q == ACCESS);
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign mem_wb_out = mem_wb_q;

`ifdef MEM_TIMEOUT_EN
  logic bus_error_q;

  mem_access_timer #(
    .Limit(TIMEOUT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clear_i  ((state_q == IDLE) && in_mem_op),
    .active_i (state_q == ACCESS),
    .ack_i    (dmem_ack),
    .timeout_o(timeout)
  );

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      bus_error_q <= 1'b0;
    end else begin
      bus_error_q <= timeout;
    end
  end

  assign bus_error = bus_error_q;
`else
  assign timeout   = 1'b0;
  assign bus_error = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: a directed vector table, hand-written
// multi-cycle sequences (back-to-back loads, reset mid-access, optional timeout)
// and a randomized run checked against a transaction-level memory model.
module tb_mem_access_stage;

  localparam logic [69:0] Init = {1'b1, 5'd3, 32'h1111_2222, 32'h3333_4444};

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [71:0] ex_mem_in = '0;
  logic        dmem_req, dmem_we, stall, bus_error;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [31:0] dmem_rdata = '0;
  logic        dmem_ack = 1'b0;
  logic [69:0] mem_wb_out;

  always #5 clk = ~clk;

  mem_access_stage #(
    .INIT_VALUE    (Init),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ex_mem_in (ex_mem_in),
    .dmem_req  (dmem_req),
    .dmem_we   (dmem_we),
    .dmem_addr (dmem_addr),
    .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata),
    .dmem_ack  (dmem_ack),
    .stall     (stall),
    .mem_wb_out(mem_wb_out),
    .bus_error (bus_error)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [71:0] mk(input logic mr, input logic mw, input logic mtr,
                                     input logic [4:0] rd, input logic [31:0] wd,
                                     input logic [31:0] alu);
    return {mr, mw, mtr, rd, wd, alu};
  endfunction

  // Write-back word the stage must produce for one instruction.
  function automatic logic [69:0] exp_wb(input logic [71:0] ex, input logic [31:0] rdata);
    logic [31:0] rfield;
    if (ex[70] || !ex[71]) rfield = 32'h0;
    else rfield = rdata;
    return {ex[69], ex[68:64], rfield, ex[31:0]};
  endfunction

  // Runs one instruction from an IDLE cycle start (just after a falling edge).
  // The bus side acks after `waits` unacknowledged ACCESS cycles.
  task automatic run_instr(input logic [71:0] ex, input int waits, input logic [31:0] rdata,
                           input logic idle_ack,
                           output logic [69:0] wb, output int stalls, output int reqs,
                           output int lat, output logic bubble_ok, output logic [31:0] addr,
                           output logic we, output logic [31:0] wdata, output logic berr);
    stalls = 0; reqs = 0; lat = 0; bubble_ok = 1'b1; berr = 1'b0;
    addr = '0; we = 1'b0; wdata = '0;
    ex_mem_in = ex;
    dmem_ack  = idle_ack;
    dmem_rdata = $urandom;
    @(posedge clk);
    if (stall) stalls++;
    if (dmem_req) reqs++;
    berr |= bus_error;
    @(negedge clk); #1;
    lat++;
    dmem_ack = 1'b0;
    if (ex[71] | ex[70]) begin
      if (mem_wb_out !== 70'h0) bubble_ok = 1'b0;
      addr = dmem_addr; we = dmem_we; wdata = dmem_wdata;
      // Upstream is frozen, but the stage must rely on its latched copy.
      ex_mem_in = {$urandom, $urandom, 8'($urandom)};
      for (int i = 0; i <= waits; i++) begin
        dmem_ack   = (i == waits);
        dmem_rdata = (i == waits) ? rdata : $urandom;
        @(posedge clk);
        if (stall) stalls++;
        if (dmem_req) reqs++;
        berr |= bus_error;
        @(negedge clk); #1;
        lat++;
        if (i != waits && mem_wb_out !== 70'h0) bubble_ok = 1'b0;
      end
      dmem_ack = 1'b0;
      if (dmem_req) bubble_ok = 1'b0;
    end
    wb = mem_wb_out;
    ex_mem_in = '0;
  endtask

  typedef struct {
    logic [71:0] ex;
    int          waits;
    logic [31:0] rdata;
    logic [69:0] wb;
    int          stalls;
  } vec_t;

  vec_t vecs[6];

  logic [31:0] mem_model [logic [31:0]];

  initial begin
    logic [69:0] wb;
    int          stalls, reqs, lat;
    logic        bub, we, berr;
    logic [31:0] addr, wdata;
    logic [3:0]  req_bits, stall_bits;

    vecs[0] = '{mk(0, 0, 0, 5'd5, 32'h0, 32'h1234), 0, 32'h0,
                {1'b0, 5'd5, 32'h0, 32'h1234}, 0};
    vecs[1] = '{mk(1, 0, 1, 5'd7, 32'h0, 32'h40), 3, 32'hDEAD_BEEF,
                {1'b1, 5'd7, 32'hDEAD_BEEF, 32'h40}, 4};
    vecs[2] = '{mk(0, 1, 0, 5'd0, 32'hCAFE, 32'h80), 0, 32'h5555_5555,
                {1'b0, 5'd0, 32'h0, 32'h80}, 1};
    vecs[3] = '{mk(1, 1, 1, 5'd9, 32'h77, 32'h100), 1, 32'hFFFF_FFFF,
                {1'b1, 5'd9, 32'h0, 32'h100}, 2};
    vecs[4] = '{mk(0, 0, 1, 5'd31, 32'hABCD, 32'hFFFF_FFFF), 0, 32'h0,
                {1'b1, 5'd31, 32'h0, 32'hFFFF_FFFF}, 0};
    vecs[5] = '{mk(1, 0, 1, 5'd1, 32'h0, 32'h4), 0, 32'h1234_5678,
                {1'b1, 5'd1, 32'h1234_5678, 32'h4}, 1};

    // Reset state
    #12;
    check("reset_wb", 72'(mem_wb_out), 72'(Init));
    check("reset_req", 72'(dmem_req), 72'(0));
    check("reset_bus_error", 72'(bus_error), 72'(0));
    check("reset_addr", 72'(dmem_addr), 72'(0));
    @(negedge clk); #1;
    check("reset_wb_held", 72'(mem_wb_out), 72'(Init));
    reset = 1'b1;

    // Directed table
    foreach (vecs[k]) begin
      logic mem_op;
      mem_op = vecs[k].ex[71] | vecs[k].ex[70];
      run_instr(vecs[k].ex, vecs[k].waits, vecs[k].rdata, 1'b0,
                wb, stalls, reqs, lat, bub, addr, we, wdata, berr);
      check($sformatf("vec%0d_wb", k), 72'(wb), 72'(vecs[k].wb));
      check($sformatf("vec%0d_stall", k), 72'(stalls), 72'(vecs[k].stalls));
      check($sformatf("vec%0d_berr", k), 72'(berr), 72'(0));
      if (mem_op) begin
        check($sformatf("vec%0d_lat", k), 72'(lat), 72'(vecs[k].waits + 2));
        check($sformatf("vec%0d_req", k), 72'(reqs), 72'(vecs[k].waits + 1));
        check($sformatf("vec%0d_bubble", k), 72'(bub), 72'(1));
        check($sformatf("vec%0d_addr", k), 72'(addr), 72'(vecs[k].ex[31:0]));
        check($sformatf("vec%0d_we", k), 72'(we), 72'(vecs[k].ex[70]));
        if (vecs[k].ex[70]) check($sformatf("vec%0d_wdata", k), 72'(wdata),
                                  72'(vecs[k].ex[63:32]));
      end else begin
        check($sformatf("vec%0d_lat", k), 72'(lat), 72'(1));
      end
    end

    // Back-to-back loads acked immediately: request pattern 0,1,0,1
    req_bits = '0;
    ex_mem_in = mk(1, 0, 1, 5'd10, 32'h0, 32'h200);
    @(posedge clk); req_bits[0] = dmem_req;
    @(negedge clk); #1;
    ex_mem_in = '0; dmem_ack = 1'b1; dmem_rdata = 32'hAAAA_0001;
    @(posedge clk); req_bits[1] = dmem_req;
    @(negedge clk); #1;
    dmem_ack = 1'b0;
    check("b2b_first_wb", 72'(mem_wb_out), 72'({1'b1, 5'd10, 32'hAAAA_0001, 32'h200}));
    ex_mem_in = mk(1, 0, 0, 5'd11, 32'h0, 32'h204);
    @(posedge clk); req_bits[2] = dmem_req;
    @(negedge clk); #1;
    ex_mem_in = '0; dmem_ack = 1'b1; dmem_rdata = 32'hBBBB_0002;
    @(posedge clk); req_bits[3] = dmem_req;
    @(negedge clk); #1;
    dmem_ack = 1'b0;
    check("b2b_second_wb", 72'(mem_wb_out), 72'({1'b0, 5'd11, 32'hBBBB_0002, 32'h204}));
    check("b2b_req_pattern", 72'(req_bits), 72'(4'b1010));

    // Reset asserted in the middle of an access
    ex_mem_in = mk(1, 0, 1, 5'd12, 32'h0, 32'h300);
    @(posedge clk);
    @(negedge clk); #1;
    ex_mem_in = '0;
    check("midrst_req_before", 72'(dmem_req), 72'(1));
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    check("midrst_req_dropped", 72'(dmem_req), 72'(0));
    check("midrst_wb_init", 72'(mem_wb_out), 72'(Init));
    @(negedge clk); #1;
    reset = 1'b1;
    dmem_ack = 1'b1;
    dmem_rdata = 32'h0BAD_0BAD;
    run_instr(mk(0, 0, 0, 5'd2, 32'h0, 32'h55), 0, 32'h0, 1'b1,
              wb, stalls, reqs, lat, bub, addr, we, wdata, berr);
    check("midrst_idle_after_wb", 72'(wb), 72'({1'b0, 5'd2, 32'h0, 32'h55}));
    check("midrst_idle_after_stall", 72'(stalls), 72'(0));

`ifdef MEM_TIMEOUT_EN
    // No ack: abort at the end of the 4th ACCESS cycle
    stall_bits = '0;
    ex_mem_in = mk(1, 0, 1, 5'd13, 32'h0, 32'h400);
    @(posedge clk);
    @(negedge clk); #1;
    ex_mem_in = '0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); stall_bits[i] = stall;
      @(negedge clk); #1;
    end
    check("tmo_stall_pattern", 72'(stall_bits), 72'(4'b0111));
    check("tmo_wb_bubble", 72'(mem_wb_out), 72'(0));
    check("tmo_bus_error_pulse", 72'(bus_error), 72'(1));
    check("tmo_req_dropped", 72'(dmem_req), 72'(0));
    @(negedge clk); #1;
    check("tmo_bus_error_end", 72'(bus_error), 72'(0));
    // Ack in the limit cycle completes normally
    run_instr(mk(1, 0, 1, 5'd14, 32'h0, 32'h404), 3, 32'h600D_F00D, 1'b0,
              wb, stalls, reqs, lat, bub, addr, we, wdata, berr);
    check("tmo_ack_wb", 72'(wb), 72'({1'b1, 5'd14, 32'h600D_F00D, 32'h404}));
    @(negedge clk); #1;
    check("tmo_ack_no_error", 72'({berr, bus_error}), 72'(0));
`endif

    // Randomized run against a word-store memory model
    for (int t = 0; t < 60; t++) begin
      logic [71:0] ex;
      logic [31:0] a, rd_val;
      int          kind, w;
      kind = int'($urandom_range(0, 3));
      w    = int'($urandom_range(0, 3));
      a    = {24'h0, 3'($urandom_range(0, 7)), 5'h0};
      ex   = mk(kind == 1 || kind == 3, kind >= 2, 1'($urandom), 5'($urandom), $urandom,
                kind == 0 ? $urandom : a);
      rd_val = mem_model.exists(a) ? mem_model[a] : $urandom;
      run_instr(ex, w, rd_val, 1'($urandom), wb, stalls, reqs, lat, bub, addr, we, wdata, berr);
      check($sformatf("rnd%0d_wb", t), 72'(wb), 72'(exp_wb(ex, rd_val)));
      check($sformatf("rnd%0d_stall", t), 72'(stalls), 72'(kind == 0 ? 0 : w + 1));
      if (kind != 0) begin
        check($sformatf("rnd%0d_bus", t), {8'h0, we, addr, 31'h0} ^ {39'h0, bub, 32'h0},
              {8'h0, ex[70], ex[31:0], 31'h0} ^ {39'h0, 1'b1, 32'h0});
        if (ex[70]) begin
          check($sformatf("rnd%0d_wdata", t), 72'(wdata), 72'(ex[63:32]));
          mem_model[a] = ex[63:32];
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
